mostrador7_mux: RTL

MOSTRADOR7_MUX -- requirements
Module: mostrador7_mux

---
 rtl/mostrador7_pkg.sv | 20 ++
 rtl/seg7_hex_decode.sv | 11 +
 rtl/mostrador7_mux.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/mostrador7_pkg.sv
// Shared types and constants for the multiplexed 7-segment display driver.
package mostrador7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  // Active-high segment patterns, bit 0 = a ... bit 6 = g, indexed by hex value.
  localparam logic [15:0][6:0] SEG7_LUT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-high 7-segment pattern.
module seg7_hex_decode
  import mostrador7_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG7_LUT[i_hex];

endmodule

// File: rtl/mostrador7_mux.sv
// Time-multiplexed N-digit 7-segment driver with blanking gaps, shadow
// registers, per-digit blink and a frame pulse; all pins are registered.
module mostrador7_mux
  import mostrador7_pkg::*;
#(
  parameter int N_DIG      = 4,
  parameter int DIV        = 50000,
  parameter int BLANK_CYC  = 2,
  parameter int BLINK_FR   = 64,
  parameter int ACTIVE_LOW = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_ld,
  input  logic [4*N_DIG-1:0] i_codes,
  input  logic [N_DIG-1:0]   i_dp,
  input  logic [N_DIG-1:0]   i_blink,
  output logic [6:0]         o_segs,
  output logic               o_seg_p,
  output logic [N_DIG-1:0]   o_seg_d,
  output logic               o_frame
);

  localparam int CW = clog2_min1((DIV > BLANK_CYC) ? DIV : BLANK_CYC);
  localparam int IW = clog2_min1(N_DIG);
  localparam int FW = clog2_min1(BLINK_FR);

  localparam logic          INV        = (ACTIVE_LOW != 0);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIG - 1);
  localparam logic [FW-1:0] FR_LAST    = FW'(BLINK_FR - 1);

  state_t             r_state, w_state_nxt;
  logic [IW-1:0]      r_idx, w_idx_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [FW-1:0]      r_fcnt, w_fcnt_nxt;
  logic               r_phase, w_phase_nxt;
  logic               r_frame, w_frame_nxt;
  logic [4*N_DIG-1:0] r_codes;
  logic [N_DIG-1:0]   r_dp, r_blink;

  logic               w_show_entry, w_dark;
  logic [3:0]         w_hex;
  logic [6:0]         w_seg_ah;
  logic [6:0]         w_segs_pin;
  logic               w_segp_pin;
  logic [N_DIG-1:0]   w_segd_pin;

  // State, counters and shadow registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_fcnt  <= '0;
      r_phase <= 1'b0;
      r_frame <= 1'b0;
      r_codes <= '0;
      r_dp    <= '0;
      r_blink <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_cnt   <= w_cnt_nxt;
      r_fcnt  <= w_fcnt_nxt;
      r_phase <= w_phase_nxt;
      r_frame <= w_frame_nxt;
      if (i_ld) begin
        r_codes <= i_codes;
        r_dp    <= i_dp;
        r_blink <= i_blink;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_fcnt_nxt  = r_fcnt;
    w_phase_nxt = r_phase;
    w_frame_nxt = 1'b0;
    if (!i_en) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
      w_fcnt_nxt  = '0;
      w_phase_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_SHOW;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
        ST_SHOW: begin
          if (r_cnt == SHOW_LAST) begin
            w_state_nxt = ST_BLANK;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        ST_BLANK: begin
          if (r_cnt == BLANK_LAST) begin
            w_state_nxt = ST_SHOW;
            w_cnt_nxt   = '0;
            if (r_idx == IDX_LAST) begin
              w_idx_nxt   = '0;
              w_frame_nxt = 1'b1;
              if (r_fcnt == FR_LAST) begin
                w_fcnt_nxt  = '0;
                w_phase_nxt = ~r_phase;
              end else begin
                w_fcnt_nxt = r_fcnt + 1'b1;
              end
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  seg7_hex_decode u_dec (
    .i_hex (w_hex),
    .o_seg (w_seg_ah)
  );

  // Pin values for the digit about to be lit; the shadow read here is the
  // pre-LD value when a load coincides with SHOW entry.
  always_comb begin
    w_show_entry = (w_state_nxt == ST_SHOW) && (r_state != ST_SHOW);
    w_hex        = r_codes[{w_idx_nxt, 2'b00} +: 4];
    w_dark       = w_phase_nxt & r_blink[w_idx_nxt];
    w_segs_pin   = (w_dark ? 7'h00 : w_seg_ah) ^ {7{INV}};
    w_segp_pin   = (~w_dark & r_dp[w_idx_nxt]) ^ INV;
    w_segd_pin   = (N_DIG'(1) << w_idx_nxt) ^ {N_DIG{INV}};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || (w_state_nxt != ST_SHOW)) begin
      o_segs  <= {7{INV}};
      o_seg_p <= INV;
      o_seg_d <= {N_DIG{INV}};
    end else if (w_show_entry) begin
      o_segs  <= w_segs_pin;
      o_seg_p <= w_segp_pin;
      o_seg_d <= w_segd_pin;
    end
  end

  assign o_frame = r_frame;

endmodule
